// File: rtl/uart_apb_pkg.sv
// Shared constants for the UART APB register front-end.
package uart_apb_pkg;

  // Word offsets, compared against paddr[3:2]
  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;
  localparam logic [1:0] AddrCtrl   = 2'd2;
  localparam logic [1:0] AddrBaud   = 2'd3;

  // STATUS bit positions
  localparam int unsigned StTxFull  = 0;
  localparam int unsigned StRxEmpty = 1;
  localparam int unsigned StErr     = 2;

  // CTRL bit positions
  localparam int unsigned CtrlRxIrqEn  = 0;
  localparam int unsigned CtrlErrIrqEn = 1;

  localparam logic [15:0] DefaultDiv = 16'd27;

endpackage

// File: rtl/uart_apb_regs_if.sv
// APB3 bus bundle between the host and the UART register front-end.
interface uart_apb_regs_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Programmable 16x-oversampling tick generator; tick period is div cycles.
module uart_baud_gen #(
  parameter logic [15:0] DEFAULT_DIV = 16'd27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] div,
  input  logic        div_load,
  output logic [15:0] div_q,
  output logic        tick
);

  logic [15:0] cnt_q;

  // Divisor register, free-running counter and registered tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DEFAULT_DIV;
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (div_load) begin
      // New divisor restarts the period from zero
      div_q <= div;
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (div_q == 16'd0) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (cnt_q == div_q - 16'd1) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + 16'd1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_apb_regs.sv
// APB3 register front-end driving the UART FIFOs, baud tick and interrupt.
module uart_apb_regs
  import uart_apb_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter logic [15:0] DEFAULT_DIV = DefaultDiv
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_apb_regs_if.slave       apb,
  output logic                 tx_fifo_wr_en,
  output logic [DATA_BITS-1:0] tx_fifo_din,
  input  logic                 tx_fifo_full,
  output logic                 rx_fifo_rd_en,
  input  logic [DATA_BITS-1:0] rx_fifo_dout,
  input  logic                 rx_fifo_empty,
  input  logic                 rx_error,
  output logic                 baud_tick,
  output logic                 irq
);

  logic        setup, access;
  logic [1:0]  word;
  logic        data_wr, status_wr, ctrl_wr, baud_wr;
  logic        rd_empty_q;
  logic        err_sticky;
  logic [1:0]  ctrl_q;
  logic [15:0] div_q;

  assign setup     = apb.psel & ~apb.penable;
  assign access    = apb.psel & apb.penable;
  assign word      = apb.paddr[3:2];
  assign data_wr   = access & apb.pwrite & (word == AddrData);
  assign status_wr = access & apb.pwrite & (word == AddrStatus);
  assign ctrl_wr   = access & apb.pwrite & (word == AddrCtrl);
  assign baud_wr   = access & apb.pwrite & (word == AddrBaud);

  assign apb.pready = 1'b1;

  // Pop is issued in setup so the byte is on rx_fifo_dout during access
  assign rx_fifo_rd_en = setup & ~apb.pwrite & (word == AddrData) & ~rx_fifo_empty & ~rst;

  // Access-phase read mux and error response; zero outside access or in reset
  always_comb begin
    apb.prdata  = '0;
    apb.pslverr = 1'b0;
    if (access && !rst) begin
      if (apb.pwrite) begin
        apb.pslverr = (word == AddrData) & tx_fifo_full;
      end else begin
        case (word)
          AddrData: begin
            if (rd_empty_q) apb.pslverr = 1'b1;
            else            apb.prdata[DATA_BITS-1:0] = rx_fifo_dout;
          end
          AddrStatus: begin
            apb.prdata[StTxFull]  = tx_fifo_full;
            apb.prdata[StRxEmpty] = rx_fifo_empty;
            apb.prdata[StErr]     = err_sticky;
          end
          AddrCtrl: apb.prdata[1:0]  = ctrl_q;
          default:  apb.prdata[15:0] = div_q;
        endcase
      end
    end
  end

  // Register writes, TX push, sticky error and interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_empty_q    <= 1'b0;
      tx_fifo_wr_en <= 1'b0;
      tx_fifo_din   <= '0;
      ctrl_q        <= '0;
      err_sticky    <= 1'b0;
      irq           <= 1'b0;
    end else begin
      // Empty decision for a DATA read is frozen at setup
      if (setup && !apb.pwrite && word == AddrData) rd_empty_q <= rx_fifo_empty;
      tx_fifo_wr_en <= data_wr & ~tx_fifo_full;
      if (data_wr && !tx_fifo_full) tx_fifo_din <= apb.pwdata[DATA_BITS-1:0];
      if (ctrl_wr) ctrl_q <= apb.pwdata[1:0];
      // Set has priority over a simultaneous clear
      if (rx_error)                             err_sticky <= 1'b1;
      else if (status_wr && apb.pwdata[StErr])  err_sticky <= 1'b0;
      irq <= (ctrl_q[CtrlRxIrqEn] & ~rx_fifo_empty) | (ctrl_q[CtrlErrIrqEn] & err_sticky);
    end
  end

  uart_baud_gen #(
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .div      (apb.pwdata[15:0]),
    .div_load (baud_wr),
    .div_q    (div_q),
    .tick     (baud_tick)
  );

endmodule

// File: tb/tb_uart_apb_regs.sv
// Directed self-checking bench for uart_apb_regs.
module tb_uart_apb_regs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_fifo_wr_en;
  logic [7:0] tx_fifo_din;
  logic       tx_fifo_full = 1'b0;
  logic       rx_fifo_rd_en;
  logic [7:0] rx_fifo_dout = 8'h00;
  logic       rx_fifo_empty = 1'b1;
  logic       rx_error = 1'b0;
  logic       baud_tick;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int rd_cnt  = 0;

  uart_apb_regs_if apb ();

  uart_apb_regs #(
    .DATA_BITS   (8),
    .DEFAULT_DIV (16'd27)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .apb           (apb),
    .tx_fifo_wr_en (tx_fifo_wr_en),
    .tx_fifo_din   (tx_fifo_din),
    .tx_fifo_full  (tx_fifo_full),
    .rx_fifo_rd_en (rx_fifo_rd_en),
    .rx_fifo_dout  (rx_fifo_dout),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_error      (rx_error),
    .baud_tick     (baud_tick),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // Pulse monitors sampled mid-cycle
  always @(negedge clk) begin
    if (tx_fifo_wr_en) wr_cnt++;
    if (rx_fifo_rd_en) rd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data, output logic err);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = addr; apb.pwdata = data;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    @(negedge clk);
    err = apb.pslverr;
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, output logic [31:0] data, output logic err,
                          output logic pop);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = addr;
    @(negedge clk);
    pop = rx_fifo_rd_en;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    @(negedge clk);
    data = apb.prdata;
    err  = apb.pslverr;
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  // Cycles until the next baud_tick, 0 if none within the budget
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (baud_tick) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        err, pop;
    int          n, ticks, wr0, rd0;

    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = 4'h0; apb.pwdata = 32'h0;
    #23 rst = 1'b0;

    // Reset state
    check("pready", {31'b0, apb.pready}, 32'd1);
    check("irq_rst", {31'b0, irq}, 32'd0);
    apb_read(4'hC, rd, err, pop);
    check("baud_rst", rd, 32'd27);
    apb_read(4'h4, rd, err, pop);
    check("status_rst", rd, 32'h2);
    wait_tick(60, n);
    wait_tick(60, n);
    check("baud_period_27", n, 32'd27);

    // TX pushes
    wr0 = wr_cnt;
    apb_write(4'h0, 32'h1234_56A5, err);
    check("tx_wr_en", {31'b0, tx_fifo_wr_en}, 32'd1);
    check("tx_din", {24'b0, tx_fifo_din}, 32'hA5);
    check("tx_err_ok", {31'b0, err}, 32'd0);
    repeat (2) @(posedge clk);
    check("tx_one_pulse", wr_cnt - wr0, 32'd1);
    tx_fifo_full = 1'b1;
    wr0 = wr_cnt;
    apb_write(4'h0, 32'h5A, err);
    repeat (2) @(posedge clk);
    check("tx_full_err", {31'b0, err}, 32'd1);
    check("tx_full_nopush", wr_cnt - wr0, 32'd0);
    tx_fifo_full = 1'b0;

    // RX pops
    rx_fifo_empty = 1'b0; rx_fifo_dout = 8'h3C;
    rd0 = rd_cnt;
    apb_read(4'h0, rd, err, pop);
    check("rx_pop_setup", {31'b0, pop}, 32'd1);
    check("rx_data", rd, 32'h3C);
    check("rx_err_ok", {31'b0, err}, 32'd0);
    check("rx_one_pop", rd_cnt - rd0, 32'd1);
    rx_fifo_empty = 1'b1;
    rd0 = rd_cnt;
    apb_read(4'h0, rd, err, pop);
    check("rx_empty_data", rd, 32'h0);
    check("rx_empty_err", {31'b0, err}, 32'd1);
    check("rx_empty_nopop", rd_cnt - rd0, 32'd0);

    // Sticky error and interrupt
    apb_write(4'h8, 32'h2, err);
    apb_read(4'h8, rd, err, pop);
    check("ctrl_rb", rd, 32'h2);
    rx_error = 1'b1;
    @(posedge clk); #1;
    rx_error = 1'b0;
    check("irq_lag", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq_err", {31'b0, irq}, 32'd1);
    apb_read(4'h4, rd, err, pop);
    check("status_err", rd, 32'h6);
    rx_error = 1'b1;
    apb_write(4'h4, 32'h4, err);
    rx_error = 1'b0;
    apb_read(4'h4, rd, err, pop);
    check("err_set_wins", rd, 32'h6);
    apb_write(4'h4, 32'h4, err);
    apb_read(4'h4, rd, err, pop);
    check("err_cleared", rd, 32'h2);
    check("irq_cleared", {31'b0, irq}, 32'd0);

    // Baud divisor changes
    wait_tick(60, n);
    repeat (5) @(posedge clk);
    apb_write(4'hC, 32'h4, err);
    wait_tick(60, n);
    check("baud4_first", n, 32'd4);
    wait_tick(60, n);
    check("baud4_period", n, 32'd4);
    apb_write(4'hC, 32'h0, err);
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (baud_tick) ticks++;
    end
    check("baud0_none", ticks, 32'd0);
    apb_write(4'hC, 32'h1, err);
    ticks = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (baud_tick) ticks++;
    end
    check("baud1_every", ticks, 32'd5);

    // Reset during a DATA-read access phase
    apb_write(4'h8, 32'h1, err);
    rx_fifo_empty = 1'b0; rx_fifo_dout = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    check("irq_rx", {31'b0, irq}, 32'd1);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 4'h0;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    rd0 = rd_cnt;
    #2 rst = 1'b1;
    #1;
    check("rst_prdata", apb.prdata, 32'h0);
    check("rst_pslverr", {31'b0, apb.pslverr}, 32'd0);
    check("rst_rd_en", {31'b0, rx_fifo_rd_en}, 32'd0);
    check("rst_wr_en", {31'b0, tx_fifo_wr_en}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_tick", {31'b0, baud_tick}, 32'd0);
    apb.psel = 1'b0; apb.penable = 1'b0;
    rx_fifo_empty = 1'b1;
    @(posedge clk); #3;
    check("rst_nopop", rd_cnt - rd0, 32'd0);
    rst = 1'b0;
    apb_read(4'hC, rd, err, pop);
    check("baud_after_rst", rd, 32'd27);
    apb_read(4'h8, rd, err, pop);
    check("ctrl_after_rst", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_apb_regs.md
# uart_apb_regs

APB3 slave register front-end that sits directly upstream of the UART top level and drives its TX FIFO write port, RX FIFO read port and baud tick. It maps a data, status, control and baud-divisor register set onto the FIFO handshakes. It keeps a sticky receive-error flag, generates the 16x-oversampling baud tick from a programmable divisor, and raises a level interrupt.

## Interface
- DATA_BITS, 8, UART character width; must match the UART top level.
- DEFAULT_DIV, 16'd27, baud divisor loaded at reset.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  APB write
- paddr  in  4  byte address; bits [1:0] ignored
- pwdata  in  32  write data
- prdata  out  32  read data
- pready  out  1  always 1 (no wait states)
- pslverr  out  1  error response, valid in access phase
- tx_fifo_wr_en  out  1  TX FIFO push pulse
- tx_fifo_din  out  DATA_BITS  TX FIFO write data
- tx_fifo_full  in  1  TX FIFO full
- rx_fifo_rd_en  out  1  RX FIFO pop pulse
- rx_fifo_dout  in  DATA_BITS  RX FIFO data, valid the cycle after rd_en
- rx_fifo_empty  in  1  RX FIFO empty
- rx_error  in  1  receiver parity/framing error, level
- baud_tick  out  1  one-cycle oversampling tick
- irq  out  1  registered interrupt, level

## Operation
- Register map (word offsets):
  - 0x0 DATA: write pushes pwdata[DATA_BITS-1:0]; read pops one RX byte, zero-extended.
  - 0x4 STATUS: bit0 tx_full, bit1 rx_empty, bit2 err_sticky. Write 1 to bit2 clears it; other bits are read-only.
  - 0x8 CTRL: bit0 rx_irq_en, bit1 err_irq_en. Read/write, reset 0.
  - 0xC BAUD: [15:0] divisor. Read/write, reset DEFAULT_DIV.
- Setup phase is psel & !penable; access phase is psel & penable.
- DATA write:
  - In the access phase with !tx_fifo_full: tx_fifo_wr_en=1 for one cycle, tx_fifo_din=pwdata[DATA_BITS-1:0].
  - If tx_fifo_full: no push, pslverr=1.
- DATA read:
  - In the setup phase with !rx_fifo_empty: rx_fifo_rd_en=1 (combinational) for one cycle.
  - In the access phase: prdata = rx_fifo_dout.
  - If rx_fifo_empty was sampled in setup: no pop, prdata=0, pslverr=1.
- Unmapped offsets (none exist within 4 bits beyond the four above) and writes to reserved bits are ignored, with no error.
- err_sticky:
  - Set in any cycle rx_error=1.
  - Cleared by a STATUS write with pwdata[2]=1.
  - Set wins over a simultaneous clear.
- Baud generator:
  - 16-bit counter increments every clk.
  - When count == div-1: baud_tick=1 for one cycle and count returns to 0.
  - div=0: tick held 0 and counter held 0. div=1: tick every cycle.
  - A BAUD write zeroes the counter in the same cycle it loads the new divisor.
- irq <= (rx_irq_en & !rx_fifo_empty) | (err_irq_en & err_sticky).

## Timing
- Reset values: prdata 0, pslverr 0, tx_fifo_wr_en 0, rx_fifo_rd_en 0, tx_fifo_din 0, baud_tick 0, irq 0, err_sticky 0, CTRL 0, BAUD DEFAULT_DIV, counter 0.
- pready is 1 combinationally. prdata and pslverr are combinational in the access phase and 0 outside it.
- Every transfer takes 2 cycles (setup, access). Back-to-back DATA reads pop one byte per transfer.
- The empty decision for a DATA read is sampled in setup. A byte arriving during the access phase is not returned.
- A register write takes effect on the clk edge ending the access phase. A STATUS read in the next transfer shows the new value.
- irq lags its sources by exactly 1 cycle.
- Reset mid-transfer aborts the transfer with no push or pop. The baud counter restarts from 0 after reset release.

## Structure
- Package uart_apb_pkg holds:
  - address offset constants DATA/STATUS/CTRL/BAUD;
  - STATUS and CTRL bit-index constants;
  - the default divisor constant.
- One sub-module, uart_baud_gen (counter, divisor, tick), with inputs div, div_load.

## Test plan
- Reset, then read BAUD and STATUS -> prdata=27, then STATUS=0x2 (rx_empty); irq=0; baud_tick pulses every 27 cycles.
- Write DATA 0xA5 with tx_fifo_full=0 -> exactly one tx_fifo_wr_en pulse with din=0xA5. Repeat with full=1 -> no pulse, pslverr=1.
- RX FIFO holds 0x3C, read DATA -> rx_fifo_rd_en in setup, prdata=0x3C, pslverr=0. Second read with empty=1 -> prdata=0, pslverr=1, no pop.
- Pulse rx_error 1 cycle with CTRL=0x2 -> STATUS bit2=1, irq=1 one cycle later. Write STATUS 0x4 while rx_error=1 -> bit stays 1.
- Write BAUD=4 mid-count -> counter zeroed, next tick 4 cycles later. BAUD=0 -> no ticks. BAUD=1 -> tick every cycle.
- Assert rst during a DATA-read access phase -> all outputs 0 immediately, no pop; after release BAUD reads 27.
